// File: rtl/mdu_pkg.sv
// Shared definitions for the M-extension datapath (multiplier, divider, decode).
// Holds the operand width, the divider state encoding and the common corner constants.
package mdu_pkg;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   localparam logic [DATA_WIDTH-1:0] INT_MIN  = 32'h8000_0000;
   localparam logic [DATA_WIDTH-1:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Divides magnitudes one quotient bit per cycle, then applies the sign fix-up.
module divider
   import mdu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  sign,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   output logic [DATA_WIDTH-1:0] Q,
   output logic [DATA_WIDTH-1:0] R,
   output logic                  busy,
   output logic                  done
);

   div_state_t            state, state_n;
   logic [DATA_WIDTH-1:0] dvd;
   logic [DATA_WIDTH-1:0] dsr;
   logic [DATA_WIDTH-1:0] rem;
   logic [4:0]            cnt;
   logic                  neg_q, neg_r;

   logic                  accept;
   logic                  div_zero;
   logic                  ovf;
   logic                  special;
   logic [DATA_WIDTH-1:0] mag_a, mag_b;
   logic [DATA_WIDTH:0]   rem_sh;
   logic [DATA_WIDTH:0]   diff;
   logic                  ge;
   logic [DATA_WIDTH-1:0] rem_nxt;

   assign accept   = start && (state == IDLE || state == DONE);
   assign div_zero = (B == '0);
   assign ovf      = sign && (A == INT_MIN) && (B == ALL_ONES);
   assign special  = div_zero || ovf;

   // INT_MIN negates to itself, which reads correctly as unsigned 2^31.
   assign mag_a = (sign && A[DATA_WIDTH-1]) ? -A : A;
   assign mag_b = (sign && B[DATA_WIDTH-1]) ? -B : B;

   // rem < dsr always holds, so bit 32 of the difference is exactly the borrow.
   assign rem_sh  = {rem, dvd[DATA_WIDTH-1]};
   assign diff    = rem_sh - {1'b0, dsr};
   assign ge      = ~diff[DATA_WIDTH];
   assign rem_nxt = ge ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];

   assign busy = (state == CALC) || (state == FIX);
   assign done = (state == DONE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // NOTE: next-state gets its default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE, DONE: if (start) state_n = special ? DONE : CALC;
         CALC:       if (cnt == 5'd31) state_n = FIX;
         FIX:        state_n = DONE;
         default:    state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd   <= '0;
         dsr   <= '0;
         rem   <= '0;
         cnt   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         Q     <= '0;
         R     <= '0;
      end else if (accept) begin
         if (special) begin
            Q <= div_zero ? ALL_ONES : INT_MIN;
            R <= div_zero ? A : '0;
         end else begin
            dvd   <= mag_a;
            dsr   <= mag_b;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= sign & (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1]);
            neg_r <= sign & A[DATA_WIDTH-1];
         end
      end else if (state == CALC) begin
         rem <= rem_nxt;
         dvd <= {dvd[DATA_WIDTH-2:0], ge};
         cnt <= cnt + 5'd1;
      end else if (state == FIX) begin
         Q <= neg_q ? -dvd : dvd;
         R <= neg_r ? -rem : rem;
      end
   end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: vector table, hand sequences and random
// operands, with expected results queued at issue and compared at done.
module tb_divider;
   import mdu_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        sign  = 1'b0;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic [31:0] q, r;
   logic        busy, done;

   int vectors    = 0;
   int miscompares = 0;

   typedef struct {
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          lat;
   } exp_t;

   exp_t sb[$];

   divider dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .sign  (sign),
      .A     (a),
      .B     (b),
      .Q     (q),
      .R     (r),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference uses language division semantics, not the shift-subtract algorithm.
   function automatic exp_t model(input logic s, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      if (y == 0) begin
         e.q = 32'hFFFF_FFFF; e.r = x; e.lat = 0;
      end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         e.q = 32'h8000_0000; e.r = 0; e.lat = 0;
      end else if (s) begin
         e.q = $signed(x) / $signed(y); e.r = $signed(x) % $signed(y); e.lat = 33;
      end else begin
         e.q = x / y; e.r = x % y; e.lat = 33;
      end
      return e;
   endfunction

   // Issues one request at a negedge; glitch>0 pulses a second start at that sample.
   // Latency is the index k of the edge E_k after which done is first seen.
   task automatic run_op(input string name, input logic s, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eq, input logic [31:0] er,
                         input int elat, input int glitch);
      exp_t e, got;
      int   k;
      int   busy_n;
      e.q = eq; e.r = er; e.lat = elat;
      sb.push_back(e);
      sign = s; a = x; b = y; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom;
      k = 0; busy_n = 0;
      while (!done && k < 100) begin
         if (busy) busy_n++;
         if (glitch > 0 && k == glitch) begin
            start = 1'b1; a = 32'd9; b = 32'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      got = sb.pop_front();
      if (k >= 100) begin
         check({name, "_timeout"}, 32'(k), 32'(got.lat));
      end else begin
         check({name, "_latency"}, 32'(k), 32'(got.lat));
         check({name, "_q"}, q, got.q);
         check({name, "_r"}, r, got.r);
         check({name, "_busy_cycles"}, 32'(busy_n), 32'(got.lat));
         check({name, "_busy_low_at_done"}, {31'b0, busy}, 32'd0);
      end
   endtask

   vec_t vt[11];
   exp_t e;

   initial begin
      vt[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
      vt[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
      vt[2]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          0};
      vt[3]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          0};
      vt[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          0};
      vt[5]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
      vt[6]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
      vt[7]  = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          33};
      vt[8]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
      vt[9]  = '{1'b1, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  0};
      vt[10] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          33};

      repeat (2) @(negedge clk);
      check("reset_q", q, 32'd0);
      check("reset_r", r, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_busy", {31'b0, busy}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++)
         run_op($sformatf("vec%0d", i), vt[i].s, vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].lat, 0);

      // A second start while busy must be ignored.
      run_op("start_in_calc", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 33, 5);

      // Asynchronous reset in the middle of a division.
      sign = 1'b0; a = 32'd12345; b = 32'd17; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("pre_reset_busy", {31'b0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_q", q, 32'd0);
      check("async_rst_r", r, 32'd0);
      check("async_rst_done", {31'b0, done}, 32'd0);
      check("async_rst_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Back-to-back from DONE: the second start is presented while done is high.
      run_op("b2b_first", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 33, 0);
      check("b2b_done_before_second", {31'b0, done}, 32'd1);
      run_op("b2b_second", 1'b1, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 33, 0);

      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 20; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = (i % 4 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (i % 5 == 1) y = -y;
            e = model(s[0], x, y);
            run_op($sformatf("rand_s%0d_%0d", s, i), s[0], x, y, e.q, e.r, e.lat, 0);
         end
      end

      // Results stay stable while idling in DONE.
      repeat (5) @(negedge clk);
      check("done_hold", {31'b0, done}, 32'd1);
      check("done_hold_q", q, e.q);
      check("done_hold_r", r, e.r);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
